vmicro16_rst_seq: RTL and testbench

Parametrised reset sequencer for multi-core vmicro16 builds. It takes the single global synchronous reset and produces one reset line per core, holding all cores for a programmable number of cycles and then releasing them one at a time at a programmable stagger. It also provides per-core and whole-system soft resets that software or a debug unit can trigger at run time. It sits between the SoC top-level reset and the `reset` inputs of every `vmicro16_core` instance, replacing direct wiring of the global reset.

---
 rtl/vmicro16_rst_seq_pkg.sv | 15 +
 rtl/vmicro16_rst_cnt.sv | 61 ++++++
 rtl/vmicro16_rst_seq.sv | 134 +++++++++++++
 tb/tb_vmicro16_rst_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vmicro16_rst_seq_pkg.sv
// Shared state encodings and default build sizes for the vmicro16 reset sequencer.
// The SoC top and the benches take their defaults from here so they agree.
package vmicro16_rst_seq_pkg;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } rst_state_e;

    localparam int DEF_CORES       = 4;
    localparam int DEF_HOLD_CYCLES = 2;
    localparam int DEF_STAGGER     = 1;

endpackage

// File: rtl/vmicro16_rst_cnt.sv
// Per-core reset flop with a soft-reset down-counter; a reload while active extends the reset.
// Latency: rst rises the edge after load and stays high for HOLD_CYCLES cycles. Backpressure: none.
module vmicro16_rst_cnt
    import vmicro16_rst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int CW          = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic rel,
    input  logic load,
    output logic rst,
    output logic rst_nxt
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          soft_q, soft_d;
    logic          rst_q, rst_d;

    always_comb begin
        cnt_d  = cnt_q;
        soft_d = soft_q;
        rst_d  = rst_q;
        if (clr) begin
            rst_d  = 1'b1;
            cnt_d  = '0;
            soft_d = 1'b0;
        end else if (rel) begin
            rst_d = 1'b0;
        end else if (load) begin
            rst_d  = 1'b1;
            cnt_d  = CW'(HOLD_CYCLES - 1);
            soft_d = 1'b1;
        end else if (soft_q) begin
            if (cnt_q == '0) begin
                rst_d  = 1'b0;
                soft_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rst_q  <= 1'b1;
            cnt_q  <= '0;
            soft_q <= 1'b0;
        end else begin
            rst_q  <= rst_d;
            cnt_q  <= cnt_d;
            soft_q <= soft_d;
        end
    end

    assign rst     = rst_q;
    assign rst_nxt = rst_d;

endmodule

// File: rtl/vmicro16_rst_seq.sv
// Power-on reset sequencer: holds all cores, releases them in index order, then serves soft resets.
// Latency: all outputs registered, no input-to-output combinational path. Backpressure: none.
module vmicro16_rst_seq
    import vmicro16_rst_seq_pkg::*;
#(
    parameter int CORES       = DEF_CORES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGGER     = DEF_STAGGER,
    parameter int CW          = $clog2(HOLD_CYCLES * STAGGER + 1) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CORES-1:0] soft_rst_req,
    input  logic             soft_all,
    output logic [CORES-1:0] rst_out,
    output logic             ready,
    output logic             busy
);

    localparam int IW = (CORES > 1) ? $clog2(CORES) : 1;

    rst_state_e    state_q, state_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [CW-1:0] stag_q, stag_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;

    logic [CORES-1:0] rel;
    logic [CORES-1:0] load;
    logic [CORES-1:0] rst_nxt;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stag_d  = stag_q;
        idx_d   = idx_q;
        ready_d = ready_q;
        rel     = '0;
        if (soft_all) begin
            state_d = S_HOLD;
            hold_d  = '0;
            stag_d  = '0;
            idx_d   = '0;
            ready_d = 1'b0;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    if (hold_q == CW'(HOLD_CYCLES - 1)) begin
                        rel[0] = 1'b1;
                        idx_d  = IW'(1);
                        stag_d = '0;
                        hold_d = '0;
                        if (CORES == 1) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d = S_RELEASE;
                        end
                    end else begin
                        hold_d = hold_q + CW'(1);
                    end
                end
                S_RELEASE: begin
                    if (stag_q == CW'(STAGGER - 1)) begin
                        stag_d = '0;
                        for (int i = 0; i < CORES; i++) begin
                            rel[i] = (idx_q == IW'(i));
                        end
                        if (idx_q == IW'(CORES - 1)) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        stag_d = stag_q + CW'(1);
                    end
                end
                S_RUN: begin
                end
                default: state_d = S_HOLD;
            endcase
        end
        // Soft requests only count once the power-on sequence has finished.
        load   = (state_q == S_RUN) ? soft_rst_req : '0;
        busy_d = |rst_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HOLD;
            hold_q  <= '0;
            stag_q  <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stag_q  <= stag_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    for (genvar g = 0; g < CORES; g++) begin : g_core
        vmicro16_rst_cnt #(
            .HOLD_CYCLES(HOLD_CYCLES),
            .CW         (CW)
        ) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .clr    (soft_all),
            .rel    (rel[g]),
            .load   (load[g]),
            .rst    (rst_out[g]),
            .rst_nxt(rst_nxt[g])
        );
    end

    assign ready = ready_q;
    assign busy  = busy_q;

`ifdef FORMAL
    initial begin
        assert (CORES >= 1);
        assert (HOLD_CYCLES >= 1);
        assert (STAGGER >= 1);
    end
`endif

endmodule

// File: tb/tb_vmicro16_rst_seq.sv
// Bench for three sequencer configurations checked every cycle against a timing-rule model.
module tb_vmicro16_rst_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v [3];
    logic       sa_v  [3];
    logic [3:0] req_v [3];
    logic [3:0] ro0;
    logic [2:0] ro1;
    logic [0:0] ro2;
    logic       rdy   [3];
    logic       bsy   [3];

    int nc [3] = '{4, 3, 1};
    int nh [3] = '{2, 4, 1};
    int ns [3] = '{1, 3, 1};

    int e0 [3];
    int su [3][4];
    bit valid [3];
    int edge_n = 0;
    int total = 0;
    int bad = 0;

    vmicro16_rst_seq #(.CORES(4), .HOLD_CYCLES(2), .STAGGER(1)) u_d0 (
        .clk(clk), .reset(rst_v[0]), .soft_rst_req(req_v[0]), .soft_all(sa_v[0]),
        .rst_out(ro0), .ready(rdy[0]), .busy(bsy[0]));

    vmicro16_rst_seq #(.CORES(3), .HOLD_CYCLES(4), .STAGGER(3)) u_d1 (
        .clk(clk), .reset(rst_v[1]), .soft_rst_req(req_v[1][2:0]), .soft_all(sa_v[1]),
        .rst_out(ro1), .ready(rdy[1]), .busy(bsy[1]));

    vmicro16_rst_seq #(.CORES(1), .HOLD_CYCLES(1), .STAGGER(1)) u_d2 (
        .clk(clk), .reset(rst_v[2]), .soft_rst_req(req_v[2][0:0]), .soft_all(sa_v[2]),
        .rst_out(ro2), .ready(rdy[2]), .busy(bsy[2]));

    // Core i is held until HOLD + i*STAGGER edges after the last restart, or through its soft window.
    function automatic logic [3:0] exp_rst(input int d, input int n);
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < nc[d]; i++)
            v[i] = ((n - e0[d]) < nh[d] + i * ns[d]) || (n <= su[d][i]);
        return v;
    endfunction

    function automatic bit exp_run(input int d, input int n);
        return (n - e0[d]) >= nh[d] + (nc[d] - 1) * ns[d];
    endfunction

    function automatic logic [3:0] act_rst(input int d);
        if (d == 0) return ro0;
        if (d == 1) return {1'b0, ro1};
        return {3'b000, ro2};
    endfunction

    task automatic chk(input string nm, input logic [3:0] a, input logic [3:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", nm, $time, a, e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edge_n = edge_n + 1;
            for (int d = 0; d < 3; d++) begin
                if (rst_v[d] || sa_v[d]) begin
                    e0[d]    = edge_n;
                    valid[d] = 1'b1;
                    for (int i = 0; i < 4; i++) su[d][i] = -1;
                end else if (valid[d] && exp_run(d, edge_n - 1)) begin
                    for (int i = 0; i < nc[d]; i++)
                        if (req_v[d][i]) su[d][i] = edge_n + nh[d] - 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (valid[d]) begin
                    chk($sformatf("rst_out[d%0d]", d), act_rst(d), exp_rst(d, edge_n));
                    chk($sformatf("ready[d%0d]", d), {3'b000, rdy[d]}, {3'b000, exp_run(d, edge_n)});
                    chk($sformatf("busy[d%0d]", d), {3'b000, bsy[d]}, {3'b000, |exp_rst(d, edge_n)});
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_v[d] = 1'b1;
            sa_v[d]  = 1'b0;
            req_v[d] = '0;
            valid[d] = 1'b0;
            e0[d]    = 0;
        end
        step(2);
        for (int d = 0; d < 3; d++) rst_v[d] = 1'b0;

        step(1);
        chk("pin_c1_rst_e1", {3'b000, ro2}, 4'b0000);
        chk("pin_c1_rdy_e1", {3'b000, rdy[2]}, 4'b0001);
        step(1);
        chk("pin_d0_e2", ro0, 4'b1110);
        step(3);
        chk("pin_d0_e5", ro0, 4'b0000);
        chk("pin_d0_rdy_e5", {3'b000, rdy[0]}, 4'b0001);
        chk("pin_d0_busy_e5", {3'b000, bsy[0]}, 4'b0000);
        chk("pin_d1_e5", {1'b0, ro1}, 4'b0110);
        step(2);
        chk("pin_d1_e7", {1'b0, ro1}, 4'b0100);
        step(3);
        chk("pin_d1_e10", {1'b0, ro1}, 4'b0000);
        chk("pin_d1_rdy_e10", {3'b000, rdy[1]}, 4'b0001);

        req_v[0] = 4'b0100;
        step(1);
        req_v[0] = 4'b0000;
        chk("pin_soft_k", ro0, 4'b0100);
        step(1);
        chk("pin_soft_k1", ro0, 4'b0100);
        chk("pin_soft_rdy", {3'b000, rdy[0]}, 4'b0001);
        step(1);
        chk("pin_soft_k2", ro0, 4'b0000);

        req_v[0] = 4'b1101;
        step(1);
        req_v[0] = 4'b0100;
        chk("pin_ext_k", ro0, 4'b1101);
        step(1);
        req_v[0] = 4'b0000;
        chk("pin_ext_k1", ro0, 4'b1101);
        step(1);
        chk("pin_ext_k2", ro0, 4'b0100);
        step(1);
        chk("pin_ext_k3", ro0, 4'b0000);

        req_v[2] = 4'b0001;
        step(1);
        req_v[2] = 4'b0000;
        chk("pin_c1_soft", {3'b000, ro2}, 4'b0001);
        step(1);
        chk("pin_c1_soft_end", {3'b000, ro2}, 4'b0000);

        rst_v[0] = 1'b1;
        step(1);
        rst_v[0] = 1'b0;
        step(3);
        chk("pin_mid_rel", ro0, 4'b1100);
        sa_v[0] = 1'b1;
        step(1);
        sa_v[0] = 1'b0;
        chk("pin_soft_all", ro0, 4'b1111);
        chk("pin_soft_all_rdy", {3'b000, rdy[0]}, 4'b0000);
        req_v[0] = 4'b1111;
        step(1);
        req_v[0] = 4'b0000;
        chk("pin_hold_req", ro0, 4'b1111);
        step(6);

        req_v[1] = 4'b0010;
        step(1);
        req_v[1] = 4'b0000;
        step(1);
        rst_v[1] = 1'b1;
        step(1);
        rst_v[1] = 1'b0;
        chk("pin_d1_rst_mid_soft", {1'b0, ro1}, 4'b0111);
        step(12);
        sa_v[1]  = 1'b1;
        req_v[1] = 4'b0111;
        step(1);
        sa_v[1]  = 1'b0;
        req_v[1] = 4'b0000;
        chk("pin_d1_sa_prio", {1'b0, ro1}, 4'b0111);
        chk("pin_d1_sa_rdy", {3'b000, rdy[1]}, 4'b0000);
        step(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
